// File: rtl/dense_layer_mac_seq.sv
// Sequential fully-connected layer: one registered signed multiplier and one accumulator
// walk all neuron/input pairs, then finalise with optional ReLU and saturation per neuron.
module dense_layer_mac_seq #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 32,
  parameter int FRAC   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            in_ready,
  input  logic                            relu,
  input  logic [N_IN*DATA_W-1:0]          x_flat,
  input  logic [N_OUT*N_IN*DATA_W-1:0]    w_flat,
  input  logic [N_OUT*DATA_W-1:0]         b_flat,
  output logic [N_OUT*DATA_W-1:0]         y_flat,
  output logic [N_OUT-1:0]                sat,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN + 1);
  localparam int N_W    = N_IN * N_OUT;
  localparam int I_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int K_W    = (N_W > 1) ? $clog2(N_W) : 1;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic signed [DATA_W-1:0] x_reg [N_IN];
  logic signed [DATA_W-1:0] w_reg [N_W];
  logic signed [DATA_W-1:0] b_reg [N_OUT];
  logic                     relu_reg;

  logic [I_W-1:0] i_cnt;
  logic [J_W-1:0] j_cnt;
  logic [K_W-1:0] k_cnt;

  logic signed [DATA_W-1:0] mult_a_p0, mult_b_p0;
  logic                     vld_p0, first_p0, last_p0;
  logic [J_W-1:0]           nidx_p0;

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext, acc_base, acc_sum, acc_p1;
  logic [DATA_W:0]          fin;

  logic signed [DATA_W-1:0] y_int [N_OUT];
  logic [N_OUT-1:0]         sat_int;
  logic [N_OUT*DATA_W-1:0]  y_pack;
  logic [N_OUT-1:0]         sat_pack;

  function automatic logic signed [ACC_W-1:0] bias_seed(input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
    return ext <<< FRAC;
  endfunction

  // Returns {clipped, y}: truncating shift, optional ReLU, then clip to the output range.
  function automatic logic [DATA_W:0] finalise(input logic signed [ACC_W-1:0] acc,
                                               input logic relu_on);
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC;
    if (relu_on && r[ACC_W-1]) r = '0;
    if (r > Y_MAX) return {1'b1, Y_MAX[DATA_W-1:0]};
    if (r < Y_MIN) return {1'b1, Y_MIN[DATA_W-1:0]};
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC:   if (k_cnt == K_W'(N_W - 1)) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, then one issue per MAC cycle into the multiplier registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++)  x_reg[i] <= '0;
      for (int k = 0; k < N_W; k++)   w_reg[k] <= '0;
      for (int j = 0; j < N_OUT; j++) b_reg[j] <= '0;
      relu_reg  <= 1'b0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      mult_a_p0 <= '0;
      mult_b_p0 <= '0;
      vld_p0    <= 1'b0;
      first_p0  <= 1'b0;
      last_p0   <= 1'b0;
      nidx_p0   <= '0;
    end else begin
      vld_p0 <= 1'b0;
      if (accept) begin
        for (int i = 0; i < N_IN; i++)  x_reg[i] <= x_flat[i*DATA_W +: DATA_W];
        for (int k = 0; k < N_W; k++)   w_reg[k] <= w_flat[k*DATA_W +: DATA_W];
        for (int j = 0; j < N_OUT; j++) b_reg[j] <= b_flat[j*DATA_W +: DATA_W];
        relu_reg <= relu;
        i_cnt    <= '0;
        j_cnt    <= '0;
        k_cnt    <= '0;
      end
      if (state == MAC) begin
        mult_a_p0 <= x_reg[i_cnt];
        mult_b_p0 <= w_reg[k_cnt];
        vld_p0    <= 1'b1;
        first_p0  <= (i_cnt == '0);
        last_p0   <= (i_cnt == I_W'(N_IN - 1));
        nidx_p0   <= j_cnt;
        k_cnt     <= k_cnt + 1'b1;
        if (i_cnt == I_W'(N_IN - 1)) begin
          i_cnt <= '0;
          j_cnt <= j_cnt + 1'b1;
        end else begin
          i_cnt <= i_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p0 -> p1: product of the registered pair is folded into the accumulator
  assign prod_p0 = PROD_W'(mult_a_p0) * PROD_W'(mult_b_p0);

  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    acc_base = first_p0 ? bias_seed(b_reg[nidx_p0]) : acc_p1;
    acc_sum  = acc_base + prod_ext;
    fin      = finalise(acc_sum, relu_reg);
  end

  // The last neuron finishes in DRAIN, so its result bypasses y_int into the visible set
  always_comb begin
    for (int j = 0; j < N_OUT; j++) y_pack[j*DATA_W +: DATA_W] = y_int[j];
    sat_pack = sat_int;
    y_pack[(N_OUT-1)*DATA_W +: DATA_W] = fin[DATA_W-1:0];
    sat_pack[N_OUT-1] = fin[DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1  <= '0;
      for (int j = 0; j < N_OUT; j++) y_int[j] <= '0;
      sat_int <= '0;
      y_flat  <= '0;
      sat     <= '0;
    end else begin
      if (vld_p0) begin
        acc_p1 <= acc_sum;
        if (last_p0) begin
          y_int[nidx_p0]   <= fin[DATA_W-1:0];
          sat_int[nidx_p0] <= fin[DATA_W];
        end
      end
      if (state == DRAIN) begin
        y_flat <= y_pack;
        sat    <= sat_pack;
      end
    end
  end

endmodule

// File: doc/dense_layer_mac_seq.md
# dense_layer_mac_seq

Parametrised fully-connected layer: computes `y[j] = act(b[j] + sum_i w[j][i]*x[i])` for N_OUT neurons over N_IN inputs in signed fixed point. It uses one shared, operand-registered multiplier and one accumulator. It is the generic successor of the fixed 4x4 layer engine in the GAN datapath, and layers of any size chain through its valid/ready ports. New behaviour over the 4x4 engine:
- operands latched at accept
- selectable ReLU
- output saturation with per-neuron flags
- output backpressure

## Interface
Parameters:
- `N_IN`, 4, inputs per neuron (>=1)
- `N_OUT`, 4, neurons (>=1)
- `DATA_W`, 32, width of x, w, b, y (signed two's complement)
- `FRAC`, 16, fractional bits of x, w, b, y (0 <= FRAC < DATA_W)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted when `start && in_ready`
- `in_ready`  out  1  high only in IDLE
- `relu`  in  1  sampled at accept; 1 = ReLU, 0 = linear
- `x_flat`  in  N_IN*DATA_W  x[i] at bits [i*DATA_W +: DATA_W]
- `w_flat`  in  N_OUT*N_IN*DATA_W  w[j][i] at bits [(j*N_IN+i)*DATA_W +: DATA_W]
- `b_flat`  in  N_OUT*DATA_W  b[j] at bits [j*DATA_W +: DATA_W]
- `y_flat`  out  N_OUT*DATA_W  results, same packing as b
- `sat`  out  N_OUT  bit j set if y[j] was clipped
- `out_valid`  out  1  result available; held until taken
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`

## Operation
- **States:** IDLE -> MAC (on accept) -> DRAIN (after last issue) -> DONE (result written) -> IDLE (on output handshake).
- **Accept:** `x_flat`, `w_flat`, `b_flat` and `relu` are copied into internal registers. Input ports are don't-care afterwards.
- **MAC issue:** one operand pair per cycle, neuron-major order (j = 0..N_OUT-1, and i = 0..N_IN-1 within each j). Pairs go into `mult_a`/`mult_b` registers.
- **Accumulate:** the product is added one cycle after issue.
- **Per-neuron accumulator:**
  - Seeded with `sign_extend(b[j]) <<< FRAC` together with the first product of neuron j.
  - The last product of neuron j is accumulated in the same cycle as the first issue of neuron j+1. There are no bubbles between neurons.
- **Widths:**
  - Product is 2*DATA_W bits.
  - Accumulator ACC_W = 2*DATA_W + clog2(N_IN+1). No internal overflow is possible.
- **Finalise per neuron**, in this order:
  1. `r = acc >>> FRAC` (arithmetic shift, truncation toward -inf, no rounding).
  2. If relu and r < 0, then r = 0.
  3. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; `sat[j]` = clip occurred.
- **Result write:** y[j] and sat[j] are written to internal registers as each neuron finishes. `y_flat`/`sat` become visible as a complete set only when DONE is entered. They hold their value until the next DONE.
- **DONE:** `out_valid` = 1 and `in_ready` = 0. `start` is ignored (never queued). Stay in DONE until `out_ready`.
- **Busy:** `start` is ignored outside IDLE.
- **Reset (any time, including mid-operation):**
  - State goes to IDLE; all registers clear.
  - `y_flat` = 0, `sat` = 0, `out_valid` = 0. `in_ready` = 1 while in IDLE.
  - Partial results are discarded.

## Timing
- Accept edge = cycle 0.
- Issues occupy cycles 1..N_IN*N_OUT.
- Last accumulate occurs at cycle N_IN*N_OUT+1 (DRAIN).
- `out_valid` rises at the edge ending cycle N_IN*N_OUT+1, i.e. visible in cycle N_IN*N_OUT+2. For 4x4 that is cycle 18.
- With `out_ready` held high: `out_valid` is high for exactly 1 cycle, then IDLE. `in_ready` = 1 the cycle after the handshake.
- Back-to-back throughput: N_IN*N_OUT+3 cycles per job.
- N_IN = 1: each neuron is seeded and completed in consecutive cycles; the same formulas apply.
- Handshake and start are sampled only on the rising edge. No combinational path from `start` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
Bench configuration: N_IN=4, N_OUT=4, DATA_W=16, FRAC=8 (1.0 = 256).
1. **Identity, linear:** x={256,512,-256,128}, w=identity (256 on diagonal), b=0, relu=0 -> y={256,512,-256,128}, sat=0, `out_valid` in cycle 18 after accept.
2. **Bias + ReLU:** same x/w, b={0,0,0,0}, relu=1 -> y={256,512,0,128}. Then b[2]=512, relu=1 -> y[2]=256. Then x[0]=-1, w[0][0]=1, b=0, linear -> y[0]=-1 (truncation toward -inf).
3. **Saturation:**
   - all x=w=b=0x7FFF -> y=0x7FFF x4, sat=4'b1111.
   - w=0x8000, x=0x7FFF, b=0 -> y=0x8000 x4, sat=4'b1111.
4. **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`, pulsing `start` meanwhile. Required: `y_flat`, `sat` and `out_valid` stay stable; `in_ready`=0; no new job starts. After `out_ready`=1 for one cycle: IDLE and `in_ready`=1 the next cycle.
5. **Operand latching:** randomise `x_flat`/`w_flat`/`b_flat` every cycle after accept -> result matches the accept-time values. Back-to-back jobs complete every 19 cycles with `out_ready`=1.
6. **Reset mid-operation:** assert `rst` at cycle 7 of a job -> `y_flat`=0, `sat`=0, `out_valid`=0 immediately (asynchronous). After release, a new job (test 1 vectors) produces the correct result at cycle 18.
